// File: rtl/fetch_stage.sv
// fetch_stage: sequential instruction fetch with a credit-limited read
// pipe and an in-order instruction queue feeding decode.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   halt                freeze issue and pop (returns still captured)
//   stall               decode busy, head entry held
//   flush, redirect_pc  redirect request and its target
//   mem_req, mem_addr   instruction read request (combinational)
//   mem_rdata           read data, fixed MEM_LAT cycles after request
//   instr_out, pc_out   head instruction and its pc
//   bubble_out          1 when instr_out/pc_out are not valid
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_LAT  = 2,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        bubble_out
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [MEM_LAT-1:0] pv_q, pv_d;
    logic [31:0]        ppc_q [MEM_LAT];
    logic [31:0]        ppc_d [MEM_LAT];
    logic [31:0]        qi_q  [DEPTH];
    logic [31:0]        qp_q  [DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;

    logic [31:0] inflight;
    logic [31:0] occ;
    logic        issue;
    logic        push;
    logic        pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + 32'(pv_q[i]);
        end
    end

    // Credits cover both queued entries and reads still in flight, so a
    // returning read always finds a free slot.
    assign occ   = 32'(count_q) + inflight;
    assign issue = rst_n && !halt && !flush && (occ < 32'(DEPTH));
    assign push  = pv_q[MEM_LAT-1] && !flush;
    assign pop   = (count_q != '0) && !stall && !halt && !flush;

    assign mem_req    = issue;
    assign mem_addr   = fetch_pc_q & 32'hFFFF_FFFC;
    assign bubble_out = (count_q == '0) || flush;
    assign instr_out  = (count_q != '0) ? qi_q[head_q] : '0;
    assign pc_out     = (count_q != '0) ? qp_q[head_q] : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pv_d       = '0;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        for (int i = 0; i < MEM_LAT; i++) begin
            ppc_d[i] = ppc_q[i];
        end

        pv_d[0]  = issue;
        ppc_d[0] = fetch_pc_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            pv_d[i]  = pv_q[i-1];
            ppc_d[i] = ppc_q[i-1];
        end

        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            tail_d = nxt(tail_q);
        end
        if (pop) begin
            head_d = nxt(head_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Redirect discards everything, including a read returning now.
        if (flush) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            pv_d       = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
            pv_q       <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pv_q       <= pv_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Datapath storage; validity is tracked by pv_q and count_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MEM_LAT; i++) begin
            ppc_q[i] <= ppc_d[i];
        end
        if (push) begin
            qi_q[tail_q] <= mem_rdata;
            qp_q[tail_q] <= ppc_q[MEM_LAT-1];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && push && !pop) begin
            assert (32'(count_q) < 32'(DEPTH))
            else $error("fetch_stage: instruction queue overflow");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized stimulus for fetch_stage,
// checked every cycle against a queue-based reference model.
module tb_fetch_stage;

    localparam int          MEM_LAT  = 2;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          NCYC     = 8192;

    typedef struct {
        int          due;
        logic [31:0] pc;
    } fly_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        bubble_out;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .MEM_LAT  (MEM_LAT),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt        (halt),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .bubble_out  (bubble_out)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        h_req  [NCYC];
    logic [31:0] h_addr [NCYC];
    logic [31:0] m_pc;
    fly_t        fly [$];
    logic [31:0] mq  [$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        halt  = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        mem_rdata = $urandom;
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_bub", 32'(bubble_out), 32'd1);
        check("rst_pc", pc_out, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_addr", mem_addr, RESET_PC);
        h_req[cyc]  = mem_req;
        h_addr[cyc] = mem_addr;
        cyc++;
        mq.delete();
        fly.delete();
        m_pc = RESET_PC;
    endtask

    task automatic step(input logic h, input logic s, input logic f,
                        input logic [31:0] rp);
        logic        er;
        logic        eb;
        logic        pop;
        logic [31:0] ep;
        logic [31:0] ei;
        int          occ;
        @(negedge clk);
        rst_n = 1'b1;
        halt  = h;
        stall = s;
        flush = f;
        redirect_pc = rp;
        if (cyc >= MEM_LAT && h_req[cyc-MEM_LAT])
            mem_rdata = word_of(h_addr[cyc-MEM_LAT]);
        else
            mem_rdata = $urandom;
        #1;
        occ = mq.size() + fly.size();
        er  = !h && !f && (occ < DEPTH);
        eb  = (mq.size() == 0) || f;
        ep  = (mq.size() != 0) ? mq[0] : 32'd0;
        ei  = (mq.size() != 0) ? word_of(mq[0]) : 32'd0;
        check("mem_req", 32'(mem_req), 32'(er));
        check("mem_addr", mem_addr, m_pc);
        check("bubble", 32'(bubble_out), 32'(eb));
        check("pc_out", pc_out, ep);
        check("instr_out", instr_out, ei);
        h_req[cyc]  = mem_req;
        h_addr[cyc] = mem_addr;
        if (f) begin
            mq.delete();
            fly.delete();
            m_pc = rp & 32'hFFFF_FFFC;
        end else begin
            pop = (mq.size() != 0) && !s && !h;
            if (fly.size() != 0 && fly[0].due == cyc) begin
                mq.push_back(fly[0].pc);
                void'(fly.pop_front());
            end
            if (pop)
                void'(mq.pop_front());
            if (er) begin
                fly.push_back('{cyc + MEM_LAT, m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        logic        rh;
        logic        rs;
        logic        rf;
        logic [31:0] rp;
        do_reset();
        do_reset();
        repeat (12) step(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'd0);
        repeat (8) step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_1002);
        repeat (8) step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_2000);
        repeat (8) step(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (8) step(1'b0, 1'b0, 1'b0, 32'd0);
        do_reset();
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (2500) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rh = ($urandom_range(0, 9) == 0);
                rs = ($urandom_range(0, 3) == 0);
                rf = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 3) == 0)
                    rp = 32'hFFFF_FFF0 + ($urandom & 32'hF);
                else
                    rp = $urandom;
                step(rh, rs, rf, rp);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
